pool_row_sequencer: RTL and testbench

Drives the running-max register (max_reg) for 1-D max pooling along a row. It accepts a row stream from upstream and issues each element to max_reg, asserting max_rst_m on the first element of every window. It captures max_reg's result after the last element of each window and presents the pooled values downstream through a 2-entry output buffer with valid/ready. It throttles upstream via pause_inputs.

---
 rtl/pool_pkg.sv | 14 +
 rtl/pool_row_sequencer_if.sv | 29 ++
 rtl/pool_obuf.sv | 74 +++++++
 rtl/pool_row_sequencer.sv | 109 ++++++++++
 tb/tb_pool_row_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// Shared constants and helpers for the 1-D max-pool row sequencer and its neighbours.
package pool_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned WIN_DEF        = 3;
    localparam int unsigned ROW_LEN_DEF    = 16;
    localparam int unsigned OBUF_DEPTH_DEF = 2;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int unsigned clog2_cnt(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_row_sequencer_if.sv
// Upstream row stream, max_reg control/result and downstream pooled stream.
interface pool_row_sequencer_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              pause_inputs;
    logic [DATA_W-1:0] max_data_in;
    logic              max_we;
    logic              max_rst_m;
    logic [DATA_W-1:0] max_reg_op;
    logic [DATA_W-1:0] pool_out;
    logic              pool_last;
    logic              pool_valid;
    logic              pool_ready;
    logic              row_done;

    modport slave (
        input  in_data, in_valid, max_reg_op, pool_ready,
        output pause_inputs, max_data_in, max_we, max_rst_m,
               pool_out, pool_last, pool_valid, row_done
    );

    modport master (
        output in_data, in_valid, max_reg_op, pool_ready,
        input  pause_inputs, max_data_in, max_we, max_rst_m,
               pool_out, pool_last, pool_valid, row_done
    );
endinterface

// File: rtl/pool_obuf.sv
// Two-entry output buffer holding {last, data}; entry 0 is always the head so outputs come straight from flops.
module pool_obuf #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              head_last_o,
    output logic              valid_o,
    output logic [1:0]        occ_o
);
    localparam int unsigned EW = DATA_W + 1;

    logic [EW-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]    occ_q, occ_d;
    logic          valid_q, valid_d;
    logic          push_ok, pop_ok;
    logic [EW-1:0] new_entry;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        new_entry = {push_last_i, push_data_i};
        pop_ok    = pop_i && valid_q;
        push_ok   = push_i && (occ_q != 2'd2);
        case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == 2'd0) head_d = new_entry;
                else               tail_d = new_entry;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new entry lands behind whatever stays.
                if (occ_q == 2'd1) begin
                    head_d = new_entry;
                end else begin
                    head_d = tail_q;
                    tail_d = new_entry;
                end
            end
            default: ;
        endcase
        valid_d = (occ_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign head_data_o = head_q[DATA_W-1:0];
    assign head_last_o = head_q[DATA_W];
    assign valid_o     = valid_q;
    assign occ_o       = occ_q;

endmodule

// File: rtl/pool_row_sequencer.sv
// Issues a row stream to an external running-max register and buffers one pooled result per window.
module pool_row_sequencer
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned WIN        = WIN_DEF,
    parameter int unsigned ROW_LEN    = ROW_LEN_DEF,
    parameter int unsigned OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 master_rst,
    pool_row_sequencer_if.slave  bus
);
    localparam int unsigned EW = clog2_cnt(WIN);
    localparam int unsigned RW = clog2_cnt(ROW_LEN);

    logic [EW-1:0]     elem_cnt_q, elem_cnt_d;
    logic [RW-1:0]     row_cnt_q, row_cnt_d;
    logic [DATA_W-1:0] max_data_in_q, max_data_in_d;
    logic              max_we_q, max_we_d;
    logic              max_rst_m_q, max_rst_m_d;
    logic              wend_q, wend_d;
    logic              rend_q, rend_d;
    logic              capture_pending_q, capture_pending_d;
    logic              last_pending_q, last_pending_d;
    logic              row_done_q, row_done_d;

    logic              accept_c, win_end_c, row_end_c, wend_in_flight_c;
    logic [1:0]        occ;
    logic              obuf_valid;

    assign row_end_c        = (row_cnt_q == RW'(ROW_LEN - 1));
    assign win_end_c        = (elem_cnt_q == EW'(WIN - 1)) || row_end_c;
    assign wend_in_flight_c = max_we_q && wend_q;

    // Reserve a buffer slot for every window result already in the pipeline.
    assign bus.pause_inputs = (3'(occ) + 3'(capture_pending_q) + 3'(wend_in_flight_c))
                              >= 3'(OBUF_DEPTH);
    assign accept_c         = bus.in_valid && !bus.pause_inputs;

    always_comb begin
        elem_cnt_d        = elem_cnt_q;
        row_cnt_d         = row_cnt_q;
        max_data_in_d     = max_data_in_q;
        max_we_d          = 1'b0;
        max_rst_m_d       = 1'b0;
        wend_d            = 1'b0;
        rend_d            = 1'b0;
        capture_pending_d = wend_in_flight_c;
        last_pending_d    = wend_in_flight_c && rend_q;
        row_done_d        = capture_pending_q && last_pending_q;
        if (accept_c) begin
            max_data_in_d = bus.in_data;
            max_we_d      = 1'b1;
            max_rst_m_d   = (elem_cnt_q == '0);
            wend_d        = win_end_c;
            rend_d        = row_end_c;
            elem_cnt_d    = win_end_c ? '0 : elem_cnt_q + EW'(1);
            row_cnt_d     = row_end_c ? '0 : row_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            elem_cnt_q        <= '0;
            row_cnt_q         <= '0;
            max_data_in_q     <= '0;
            max_we_q          <= 1'b0;
            max_rst_m_q       <= 1'b0;
            wend_q            <= 1'b0;
            rend_q            <= 1'b0;
            capture_pending_q <= 1'b0;
            last_pending_q    <= 1'b0;
            row_done_q        <= 1'b0;
        end else begin
            elem_cnt_q        <= elem_cnt_d;
            row_cnt_q         <= row_cnt_d;
            max_data_in_q     <= max_data_in_d;
            max_we_q          <= max_we_d;
            max_rst_m_q       <= max_rst_m_d;
            wend_q            <= wend_d;
            rend_q            <= rend_d;
            capture_pending_q <= capture_pending_d;
            last_pending_q    <= last_pending_d;
            row_done_q        <= row_done_d;
        end
    end

    // max_reg_op already holds the finished window when capture is pending.
    pool_obuf #(.DATA_W(DATA_W)) u_obuf (
        .clk         (clk),
        .rst         (master_rst),
        .push_i      (capture_pending_q),
        .push_data_i (bus.max_reg_op),
        .push_last_i (last_pending_q),
        .pop_i       (bus.pool_valid && bus.pool_ready),
        .head_data_o (bus.pool_out),
        .head_last_o (bus.pool_last),
        .valid_o     (obuf_valid),
        .occ_o       (occ)
    );

    assign bus.pool_valid  = obuf_valid;
    assign bus.max_data_in = max_data_in_q;
    assign bus.max_we      = max_we_q;
    assign bus.max_rst_m   = max_rst_m_q;
    assign bus.row_done    = row_done_q;

endmodule

// File: tb/tb_pool_row_sequencer.sv
// Directed bench for pool_row_sequencer with a behavioural max_reg on each instance.
module tb_pool_row_sequencer;

    logic clk;
    logic master_rst;

    pool_row_sequencer_if #(.DATA_W(32)) bus ();
    pool_row_sequencer_if #(.DATA_W(32)) bus1 ();

    pool_row_sequencer #(.DATA_W(32), .WIN(3), .ROW_LEN(16), .OBUF_DEPTH(2)) dut (
        .clk        (clk),
        .master_rst (master_rst),
        .bus        (bus.slave)
    );

    pool_row_sequencer #(.DATA_W(32), .WIN(1), .ROW_LEN(4), .OBUF_DEPTH(2)) dut1 (
        .clk        (clk),
        .master_rst (master_rst),
        .bus        (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural max_reg models.
    logic [31:0] mreg  = '0;
    logic [31:0] mreg1 = '0;
    always @(posedge clk) begin
        if (bus.max_we)
            mreg <= bus.max_rst_m ? bus.max_data_in
                  : ((mreg > bus.max_data_in) ? mreg : bus.max_data_in);
        if (bus1.max_we)
            mreg1 <= bus1.max_rst_m ? bus1.max_data_in
                   : ((mreg1 > bus1.max_data_in) ? mreg1 : bus1.max_data_in);
    end
    assign bus.max_reg_op  = mreg;
    assign bus1.max_reg_op = mreg1;

    int tests  = 0;
    int failed = 0;

    logic [31:0] got_d[$];
    logic        got_l[$];
    logic [31:0] rstm_q[$];
    int          rd_cnt, stall_cnt;
    logic [31:0] g1_d[$];
    logic        g1_l[$];
    int          g1_rd, g1_we, g1_rm;

    logic [31:0] vals[16];
    int          vidx;

    // Output monitors sample on the falling edge.
    always @(negedge clk) begin
        if (!master_rst) begin
            if (bus.pool_valid && bus.pool_ready) begin
                got_d.push_back(bus.pool_out);
                got_l.push_back(bus.pool_last);
            end
            if (bus.row_done) rd_cnt++;
            if (bus.max_we && bus.max_rst_m) rstm_q.push_back(bus.max_data_in);
            if (bus1.pool_valid && bus1.pool_ready) begin
                g1_d.push_back(bus1.pool_out);
                g1_l.push_back(bus1.pool_last);
            end
            if (bus1.row_done) g1_rd++;
            if (bus1.max_we) g1_we++;
            if (bus1.max_we && bus1.max_rst_m) g1_rm++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_d.delete(); got_l.delete(); rstm_q.delete();
        rd_cnt = 0; stall_cnt = 0;
    endtask

    task automatic do_reset();
        master_rst   = 1'b1;
        bus.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 master_rst = 1'b0;
    endtask

    // Present vals[vidx..upto-1]; acceptance is decided from pause_inputs before the edge.
    task automatic drive(input int upto, input bit gaps, input int budget);
        int cyc = 0;
        bit phase = 1'b0;
        while (vidx < upto && cyc < budget) begin
            bus.in_valid = !(gaps && phase);
            bus.in_data  = vals[vidx];
            @(negedge clk);
            if (bus.in_valid && bus.pause_inputs) stall_cnt++;
            if (bus.in_valid && !bus.pause_inputs) vidx++;
            @(posedge clk);
            #1;
            phase = !phase;
            cyc++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int c = 0;
        while (got_d.size() < n && c < 100) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_rows(input string tag, input logic [31:0] exp[6], input int n);
        check({tag, "_count"}, 32'(got_d.size()), 32'(n));
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_d[i], exp[i]);
            check($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == n - 1));
        end
    endtask

    initial begin
        logic [31:0] e[6];
        logic [31:0] v1[4];
        int j;

        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.pool_ready  = 1'b1;
        bus1.in_data    = '0;
        bus1.in_valid   = 1'b0;
        bus1.pool_ready = 1'b1;
        rd_cnt = 0; stall_cnt = 0; g1_rd = 0; g1_we = 0; g1_rm = 0;

        do_reset();
        @(negedge clk);
        check("rst_pool_valid", 32'(bus.pool_valid), 0);
        check("rst_pool_out", bus.pool_out, 0);
        check("rst_pool_last", 32'(bus.pool_last), 0);
        check("rst_row_done", 32'(bus.row_done), 0);
        check("rst_max_we", 32'(bus.max_we), 0);
        check("rst_max_rst_m", 32'(bus.max_rst_m), 0);
        check("rst_max_data_in", bus.max_data_in, 0);
        check("rst_pause", 32'(bus.pause_inputs), 0);
        @(posedge clk); #1;

        // 1: ascending row, continuous, downstream always ready
        clear_mon();
        for (int i = 0; i < 16; i++) vals[i] = 32'(i + 1);
        vidx = 0;
        drive(16, 1'b0, 100);
        wait_out(6);
        check("t1_sent", 32'(vidx), 16);
        e = '{3, 6, 9, 12, 15, 16};
        check_rows("t1", e, 6);
        check("t1_row_done", 32'(rd_cnt), 1);
        check("t1_stalls", 32'(stall_cnt), 0);
        e = '{1, 4, 7, 10, 13, 16};
        check("t1_rstm_count", 32'(rstm_q.size()), 6);
        for (int i = 0; i < 6 && i < rstm_q.size(); i++)
            check($sformatf("t1_rstm%0d", i), rstm_q[i], e[i]);

        // 2: descending row, window load must drop the previous max
        clear_mon();
        for (int i = 0; i < 16; i++) vals[i] = 32'(16 - i);
        vidx = 0;
        drive(16, 1'b0, 100);
        wait_out(6);
        e = '{16, 13, 10, 7, 4, 1};
        check_rows("t2", e, 6);
        check("t2_row_done", 32'(rd_cnt), 1);

        // 3: downstream stalled, buffer fills and upstream is paused
        clear_mon();
        for (int i = 0; i < 16; i++) vals[i] = 32'(i + 1);
        vidx = 0;
        bus.pool_ready = 1'b0;
        drive(16, 1'b0, 20);
        @(negedge clk);
        check("t3_accepted", 32'(vidx), 6);
        check("t3_pause", 32'(bus.pause_inputs), 1);
        check("t3_valid", 32'(bus.pool_valid), 1);
        check("t3_head", bus.pool_out, 3);
        check("t3_head_last", 32'(bus.pool_last), 0);
        @(posedge clk); #1;
        bus.pool_ready = 1'b1;
        drive(16, 1'b0, 100);
        wait_out(6);
        e = '{3, 6, 9, 12, 15, 16};
        check_rows("t3", e, 6);
        check("t3_row_done", 32'(rd_cnt), 1);

        // 4: in_valid toggling every other cycle
        clear_mon();
        vals = '{5, 2, 9, 1, 1, 7, 3, 8, 4, 0, 6, 2, 11, 10, 12, 1};
        vidx = 0;
        drive(16, 1'b1, 100);
        wait_out(6);
        e = '{9, 7, 8, 6, 12, 1};
        check_rows("t4", e, 6);

        // 5: reset in the middle of a window
        clear_mon();
        for (int i = 0; i < 16; i++) vals[i] = 32'(i + 1);
        vidx = 0;
        drive(8, 1'b0, 50);
        repeat (4) @(posedge clk); #1;
        check("t5_pre_count", 32'(got_d.size()), 2);
        do_reset();
        clear_mon();
        @(negedge clk);
        check("t5_rst_valid", 32'(bus.pool_valid), 0);
        check("t5_rst_we", 32'(bus.max_we), 0);
        @(posedge clk); #1;
        vidx = 0;
        drive(16, 1'b0, 100);
        wait_out(6);
        e = '{3, 6, 9, 12, 15, 16};
        check_rows("t5", e, 6);
        check("t5_row_done", 32'(rd_cnt), 1);

        // 6: WIN=1 instance, every element a window, push and pop overlap
        v1 = '{10, 3, 7, 20};
        j = 0;
        for (int c = 0; c < 40 && j < 4; c++) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = v1[j];
            @(negedge clk);
            if (!bus1.pause_inputs) j++;
            @(posedge clk); #1;
        end
        bus1.in_valid = 1'b0;
        repeat (8) @(posedge clk); #1;
        check("t6_sent", 32'(j), 4);
        check("t6_count", 32'(g1_d.size()), 4);
        for (int i = 0; i < 4 && i < g1_d.size(); i++) begin
            check($sformatf("t6_data%0d", i), g1_d[i], v1[i]);
            check($sformatf("t6_last%0d", i), 32'(g1_l[i]), 32'(i == 3));
        end
        check("t6_we", 32'(g1_we), 4);
        check("t6_rstm", 32'(g1_rm), 4);
        check("t6_row_done", 32'(g1_rd), 1);
        check("t6_valid_idle", 32'(bus1.pool_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
